// File: rtl/rv32m_muldiv_if.sv
// Operand/writeback bundle between the issue stage and the RV32M multiply/divide unit.
interface rv32m_muldiv_if;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] busA;
  logic [31:0] busB;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  Rw;
  logic        RegWr;

  // Pipeline side: issues operations, observes the writeback.
  modport master (
    output start, flush, funct3, busA, busB, rd_in,
    input  busy, done, result, Rw, RegWr
  );

  // Unit side: consumes operands, produces the writeback.
  modport slave (
    input  start, flush, funct3, busA, busB, rd_in,
    output busy, done, result, Rw, RegWr
  );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and
// restoring divide on magnitudes, with a final sign fix-up. Division by zero
// and signed overflow can optionally complete straight from IDLE.
module rv32m_muldiv #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  rv32m_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [63:0]       acc_q, acc_d;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opnd_q, opnd_d;    // mul: multiplicand magnitude; div: divisor magnitude
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d, regwr_q, regwr_d;

  // Two's-complement magnitude of a 32-bit operand when it is treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_neg);
    mag32 = is_neg ? (~x + 32'd1) : x;
  endfunction

  // Conditional two's-complement negate of a 64-bit value.
  function automatic logic [63:0] cneg64(input logic [63:0] x, input logic do_neg);
    cneg64 = do_neg ? (~x + 64'd1) : x;
  endfunction

  logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s, is_div_s;
  logic        b_zero_s, ovf_s, special_s, neg_start_s, accept_s;
  logic [31:0] abs_a_s, abs_b_s, special_res_s;
  logic [32:0] sum_s, rem_sh_s, diff_s;
  logic [63:0] step_acc_s, fixed_s;
  logic [31:0] final_res_s;

  // Decode the incoming operation: operand signedness, magnitudes, special cases.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      3'b010:                         begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      default:                        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    is_div_s      = bus.funct3[2];
    a_neg_s       = a_signed_s & bus.busA[31];
    b_neg_s       = b_signed_s & bus.busB[31];
    abs_a_s       = mag32(bus.busA, a_neg_s);
    abs_b_s       = mag32(bus.busB, b_neg_s);
    b_zero_s      = (bus.busB == 32'h0000_0000);
    ovf_s         = ~bus.funct3[0] & (bus.busA == 32'h8000_0000) & (bus.busB == 32'hFFFF_FFFF);
    special_s     = FAST_SPECIAL & is_div_s & (b_zero_s | ovf_s);
    accept_s      = bus.start & ~bus.flush;
    // Quotient of x/0 is all-ones unsigned, so it must never be negated.
    if (!is_div_s) begin
      neg_start_s = a_neg_s ^ b_neg_s;
    end else if (bus.funct3[1]) begin
      neg_start_s = a_neg_s;
    end else begin
      neg_start_s = b_zero_s ? 1'b0 : (a_neg_s ^ b_neg_s);
    end
    if (b_zero_s) begin
      special_res_s = bus.funct3[1] ? bus.busA : 32'hFFFF_FFFF;
    end else begin
      special_res_s = bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // One iteration of the multiply or divide step, plus final sign fix-up.
  always_comb begin
    sum_s    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    rem_sh_s = {acc_q[63:32], acc_q[31]};
    diff_s   = rem_sh_s - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!diff_s[32]) begin
        step_acc_s = {diff_s[31:0], acc_q[30:0], 1'b1};
      end else begin
        step_acc_s = {rem_sh_s[31:0], acc_q[30:0], 1'b0};
      end
    end else begin
      step_acc_s = {sum_s, acc_q[31:1]};
    end
    if (op_q[2]) begin
      fixed_s     = cneg64(op_q[1] ? {32'd0, step_acc_s[63:32]} : {32'd0, step_acc_s[31:0]}, neg_q);
      final_res_s = fixed_s[31:0];
    end else begin
      fixed_s     = cneg64(step_acc_s, neg_q);
      final_res_s = (op_q[1:0] == 2'b00) ? fixed_s[31:0] : fixed_s[63:32];
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush aborts an operation in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = special_s ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 6'd31) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs for the coming cycle, derived from the next state.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    regwr_d = done_d & (rd_d != 5'd0);
  end

  // Datapath next values: capture at accept, iterate in CALC, hold otherwise.
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d   = bus.funct3;
          rd_d   = bus.rd_in;
          neg_d  = neg_start_s;
          cnt_d  = 6'd0;
          acc_d  = is_div_s ? {32'd0, abs_a_s} : {32'd0, abs_b_s};
          opnd_d = is_div_s ? abs_b_s : abs_a_s;
          if (special_s) begin
            result_d = special_res_s;
          end else begin
            result_d = result_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CALC: begin
        if (!bus.flush) begin
          acc_d = step_acc_s;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_d = final_res_s;
          end else begin
            result_d = result_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      regwr_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      regwr_q  <= regwr_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.RegWr  = regwr_q;
  assign bus.result = result_q;
  assign bus.Rw     = rd_q;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Randomized self-checking bench for rv32m_muldiv against a cycle-count
// behavioural model built on plain 64-bit arithmetic.
module tb_rv32m_muldiv;

  logic clk = 1'b0;
  logic rst;
  rv32m_muldiv_if bus();

  rv32m_muldiv #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference result straight from the RV32M arithmetic definition.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'b000: begin p = sa * sb; ref_op = p[31:0]; end
      3'b001: begin p = sa * sb; ref_op = p[63:32]; end
      3'b010: begin p = sa * ub; ref_op = p[63:32]; end
      3'b011: begin p = ua * ub; ref_op = p[63:32]; end
      3'b100: begin
        if (b == 32'd0) ref_op = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = 32'h8000_0000;
        else begin p = sa / sb; ref_op = p[31:0]; end
      end
      3'b101: ref_op = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) ref_op = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = 32'd0;
        else begin p = sa % sb; ref_op = p[31:0]; end
      end
      default: ref_op = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    is_special = f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, got, exp);
  endtask

  // Behavioural model: idle / busy with a countdown to the done cycle.
  logic        m_busy, m_done, m_regwr;
  logic [31:0] m_result, m_pend;
  logic [4:0]  m_rw;
  int          m_left;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_regwr <= 1'b0;
      m_result <= 32'd0; m_rw <= 5'd0; m_left <= 0; m_pend <= 32'd0;
    end else if (!m_busy) begin
      m_done <= 1'b0; m_regwr <= 1'b0;
      if (bus.start && !bus.flush) begin
        m_busy <= 1'b1;
        m_rw   <= bus.rd_in;
        if (is_special(bus.funct3, bus.busA, bus.busB)) begin
          m_done   <= 1'b1;
          m_regwr  <= (bus.rd_in != 5'd0);
          m_result <= ref_op(bus.funct3, bus.busA, bus.busB);
          m_left   <= 0;
        end else begin
          m_pend <= ref_op(bus.funct3, bus.busA, bus.busB);
          m_left <= 32;
        end
      end
    end else if (bus.flush || m_left == 0) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_regwr <= 1'b0;
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done   <= 1'b1;
        m_regwr  <= (m_rw != 5'd0);
        m_result <= m_pend;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mon_busy",   {31'd0, bus.busy},  {31'd0, m_busy});
      cmp("mon_done",   {31'd0, bus.done},  {31'd0, m_done});
      cmp("mon_regwr",  {31'd0, bus.RegWr}, {31'd0, m_regwr});
      cmp("mon_rw",     {27'd0, bus.Rw},    {27'd0, m_rw});
      cmp("mon_result", bus.result,         m_result);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output int lat,
                       output logic regwr);
    bus.start = 1'b1; bus.funct3 = f; bus.busA = a; bus.busB = b; bus.rd_in = rd;
    cyc();
    bus.start = 1'b0;
    bus.busA = $urandom; bus.busB = $urandom; bus.rd_in = 5'($urandom);
    lat = 1;
    while (!bus.done && lat < 40) begin
      cyc();
      lat++;
    end
    if (!bus.done) begin
      n_checks++;
      $display("FAIL timeout_done t=%0t actual=no_done required=done", $time);
    end
    res   = bus.result;
    regwr = bus.RegWr;
    cyc();
  endtask

  task automatic directed(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat;
    logic        rw;
    cmp({nm, "_model"}, ref_op(f, a, b), exp);
    do_op(f, a, b, 5'd7, res, lat, rw);
    cmp(nm, res, exp);
    cmp({nm, "_lat"}, lat, exp_lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       pick = 32'd0;
      1:       pick = 32'hFFFF_FFFF;
      2:       pick = 32'h8000_0000;
      3:       pick = $urandom_range(0, 20);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, prev;
    int          lat;
    logic        rw;

    rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
    bus.busA = 32'd0; bus.busB = 32'd0; bus.rd_in = 5'd0;
    cyc(); cyc();
    chk_en = 1'b1;
    cmp("reset_result", bus.result, 32'd0);
    cmp("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    cyc();

    // MUL 7 * -3 into x5, with busy high across all 33 cycles.
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.busA = 32'd7; bus.busB = 32'hFFFF_FFFD; bus.rd_in = 5'd5;
    cyc();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) cmp("mul_busy", 32'd0, 32'd1);
      cyc();
      lat++;
    end
    cmp("mul_res", bus.result, 32'hFFFF_FFEB);
    cmp("mul_lat", lat, 33);
    cmp("mul_regwr", {31'd0, bus.RegWr}, 32'd1);
    cmp("mul_rw", {27'd0, bus.Rw}, 32'd5);
    cyc();

    directed("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    directed("mulh",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    directed("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
    directed("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    directed("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    directed("divu",    3'b101, 32'd100,       32'd7,         32'd14,        33);
    directed("remu",    3'b111, 32'd100,       32'd7,         32'd2,         33);
    directed("divu0",   3'b101, 32'h0BAD_F00D, 32'd0,         32'hFFFF_FFFF, 1);
    directed("rem0",    3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 1);
    directed("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // rd=0: result written back but no register write.
    do_op(3'b000, 32'd3, 32'd4, 5'd0, res, lat, rw);
    cmp("rd0_res", res, 32'd12);
    cmp("rd0_regwr", {31'd0, rw}, 32'd0);

    // Flush at iteration 10: no done, result kept, next start works.
    prev = bus.result;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.busA = 32'd5; bus.busB = 32'd6; bus.rd_in = 5'd9;
    cyc();
    bus.start = 1'b0;
    repeat (10) cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    cmp("flush_busy", {31'd0, bus.busy}, 32'd0);
    cmp("flush_done", {31'd0, bus.done}, 32'd0);
    cmp("flush_res", bus.result, prev);
    do_op(3'b101, 32'd1000, 32'd10, 5'd3, res, lat, rw);
    cmp("after_flush", res, 32'd100);

    // Start pulsed during CALC is ignored.
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.busA = 32'd90; bus.busB = 32'd9; bus.rd_in = 5'd4;
    cyc();
    bus.start = 1'b0;
    repeat (5) cyc();
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.busA = 32'd2; bus.busB = 32'd2; bus.rd_in = 5'd8;
    cyc();
    bus.start = 1'b0;
    lat = 7;
    while (!bus.done && lat < 40) begin
      cyc();
      lat++;
    end
    cmp("ign_start_res", bus.result, 32'd10);
    cmp("ign_start_lat", lat, 33);
    cmp("ign_start_rw", {27'd0, bus.Rw}, 32'd4);
    cyc();

    // Reset at iteration 20 clears every output at the next edge.
    bus.start = 1'b1; bus.funct3 = 3'b011; bus.busA = 32'hDEAD_BEEF; bus.busB = 32'h1234_5678; bus.rd_in = 5'd12;
    cyc();
    bus.start = 1'b0;
    repeat (20) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cmp("rst_busy",   {31'd0, bus.busy},  32'd0);
    cmp("rst_done",   {31'd0, bus.done},  32'd0);
    cmp("rst_regwr",  {31'd0, bus.RegWr}, 32'd0);
    cmp("rst_result", bus.result,         32'd0);
    cmp("rst_rw",     {27'd0, bus.Rw},    32'd0);

    // Randomized operations, checked by the model every cycle and here by value.
    for (int i = 0; i < 80; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = pick();
      b = pick();
      do_op(f, a, b, 5'($urandom), res, lat, rw);
      cmp("rand_res", res, ref_op(f, a, b));
      cmp("rand_lat", lat, is_special(f, a, b) ? 1 : 33);
      repeat ($urandom_range(0, 2)) cyc();
    end

    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv.md
Name: rv32m_muldiv

Overview:
Iterative RV32M multiply/divide unit that sits directly downstream of the register file. It consumes the busA/busB operands read for an M-extension instruction and produces a writeback (Rw, RegWr, result) that drives the register-file write port. One operation is in flight at a time. The pipeline stalls on busy.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete in 1 cycle without iterating; when 0, they follow the normal 32-cycle path with the same result.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only in IDLE
flush  input  1  abort the current operation (pipeline kill)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
busA  input  32  rs1 operand (dividend / multiplicand)
busB  input  32  rs2 operand (divisor / multiplier)
rd_in  input  5  destination register index
busy  output  1  high while in CALC or DONE; the pipeline stalls on busy
done  output  1  one-cycle pulse; result is valid in that cycle
result  output  32  registered result; held until the next accepted start
Rw  output  5  captured rd_in
RegWr  output  1  high only in the done cycle, and only when Rw != 0

Behaviour:
- Reset: on a clk edge with rst=1 the unit goes to IDLE and busy=0, done=0, RegWr=0, result=0, Rw=0. Reset wins over every other input, including mid-operation.
- States: IDLE, CALC, DONE.
- IDLE -> CALC:
  - Taken when start=1 and flush=0.
  - At that edge, capture funct3 and rd_in, the absolute values of the signed operands, and the sign of the final result.
  - Signed/unsigned operand treatment: MUL and MULH treat both operands as signed. MULHSU treats busA as signed and busB as unsigned. MULHU, DIVU and REMU treat both as unsigned. DIV and REM treat both as signed.
- IDLE special-case path (division only, FAST_SPECIAL=1): IDLE -> DONE on start when either condition holds.
  - busB==0: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=busA.
  - Signed DIV/REM with busA=0x80000000 and busB=0xFFFFFFFF: DIV result=0x80000000; REM result=0.
- CALC: 6-bit iteration counter runs 0..31, one step per cycle.
  - Multiply: shift-add into a 64-bit unsigned product.
  - Divide: restoring division, one quotient bit per cycle, 32-bit remainder.
  - After step 31: final sign correction (two's-complement negate of the 64-bit product, quotient or remainder as required), result is registered, and the state moves to DONE.
- Result and sign rules:
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - The quotient sign is the XOR of the operand signs.
  - The remainder sign equals the dividend sign.
- DONE: lasts exactly one cycle with done=1 and RegWr=(Rw!=0), then goes to IDLE. start in DONE is ignored.
- Latency, with start accepted at edge N:
  - Normal operation: done is high in the cycle after edge N+32, i.e. 33 cycles after start.
  - Special case: done is high in the cycle after edge N.
- busy is high from the edge after start through the DONE cycle inclusive.
- start in CALC is ignored.
- flush:
  - In CALC or DONE, the next edge goes to IDLE with done=0 and RegWr=0; result keeps its prior value.
  - In IDLE, flush=1 blocks start.
- result, Rw and funct3 remain stable between done and the next accepted start.

Test Plan:
- MUL busA=7, busB=0xFFFFFFFD (-3) -> result=0xFFFFFFEB; done 33 cycles after start; RegWr=1 with Rw=rd_in=5; busy high for 33 cycles.
- MULHU busA=busB=0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU busA=0xFFFFFFFF, busB=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases (FAST_SPECIAL=1), each with done exactly 1 cycle after start:
  - DIVU x/0 -> 0xFFFFFFFF.
  - REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Mid-operation abort and ignored inputs:
  - flush at iteration 10 -> IDLE next cycle, no done pulse, result unchanged; a new start is then accepted normally.
  - rst asserted at iteration 20 -> all outputs 0 at the next edge.
  - start pulsed during CALC -> ignored, original result unaffected.
- rd_in=0 with MUL 3*4 -> done=1, result=12, RegWr=0.
